// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard controller: data-hazard stalls, memory-wait sequencing, redirect flushes
//
// Ports:
//   clock, reset_n            core clock, asynchronous active-low reset
//   forwarding_type_id        operand-need class of the instruction in ID
//   reg_we_ex/mem             EX/MEM instruction writes rd
//   mem_rd_ex/mem             EX/MEM instruction is a load
//   rd_ex, rd_mem             EX/MEM destination registers
//   rs1_id, rs2_id            ID source registers
//   mem_req_mem, mem_ack      MEM-stage data access request / completion
//   branch_taken              decode-resolved redirect
//   trap                      trap/interrupt redirect from MEM
//   stall_if/id/ex/mem        per-stage hold strobes
//   flush_id/ex/mem           per-stage clear strobes
//   stall_count               saturating count of cycles with stall_if set

package hazard_pkg;
  typedef enum logic [1:0] {
    NoForward            = 2'd0,
    ForwardExecute       = 2'd1,
    ForwardExecuteMemory = 2'd2,
    ForwardDecode        = 2'd3
  } forwarding_type_t;
endpackage

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int N     = 5,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  forwarding_type_t forwarding_type_id,
  input  logic             reg_we_ex,
  input  logic             reg_we_mem,
  input  logic             mem_rd_ex,
  input  logic             mem_rd_mem,
  input  logic [N-1:0]     rd_ex,
  input  logic [N-1:0]     rd_mem,
  input  logic [N-1:0]     rs1_id,
  input  logic [N-1:0]     rs2_id,
  input  logic             mem_req_mem,
  input  logic             mem_ack,
  input  logic             branch_taken,
  input  logic             trap,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   trap_pend_q, trap_pend_d;
  logic   [CNT_W-1:0] cnt_q;

  logic load_use_ex;
  logic load_use_mem;
  logic data_hazard;

  logic stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
  logic flush_id_c, flush_ex_c, flush_mem_c;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic dep(input logic [N-1:0] rs, input logic [N-1:0] rd, input logic we);
    return we && (rs != '0) && (rs == rd);
  endfunction

  // Data hazards: only loads are a problem, since ALU results are forwarded.
  // Decode-consumers (branches) additionally cannot take a load result from MEM.
  always_comb begin
    load_use_ex  = mem_rd_ex  && (dep(rs1_id, rd_ex,  reg_we_ex)  || dep(rs2_id, rd_ex,  reg_we_ex));
    load_use_mem = mem_rd_mem && (dep(rs1_id, rd_mem, reg_we_mem) || dep(rs2_id, rd_mem, reg_we_mem));
    data_hazard  = 1'b0;
    case (forwarding_type_id)
      ForwardExecute,
      ForwardExecuteMemory: data_hazard = load_use_ex;
      ForwardDecode:        data_hazard = load_use_ex || load_use_mem;
      default:              data_hazard = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      trap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trap_pend_q <= trap_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    trap_pend_d = trap_pend_q;
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    stall_ex_c  = 1'b0;
    stall_mem_c = 1'b0;
    flush_id_c  = 1'b0;
    flush_ex_c  = 1'b0;
    flush_mem_c = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        if (!mem_ack) begin
          // Freeze the whole pipe; a trap must wait for the bus to finish.
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          stall_ex_c  = 1'b1;
          stall_mem_c = 1'b1;
          trap_pend_d = trap_pend_q | trap;
        end else if (trap || trap_pend_q) begin
          flush_id_c  = 1'b1;
          flush_ex_c  = 1'b1;
          flush_mem_c = 1'b1;
          trap_pend_d = 1'b0;
          state_d     = FLUSH;
        end else begin
          // Release cycle: the memory stall drops, but ID may still need a bubble.
          state_d = IDLE;
          if (data_hazard) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
          end
        end
      end

      default: begin
        if (trap) begin
          flush_id_c  = 1'b1;
          flush_ex_c  = 1'b1;
          flush_mem_c = 1'b1;
          state_d     = FLUSH;
        end else begin
          state_d = (mem_req_mem && !mem_ack) ? MEM_WAIT : IDLE;
          if (state_q == FLUSH) begin
            // The slot fetched during the trap cycle is still wrong-path.
            flush_id_c = 1'b1;
          end else if (data_hazard) begin
            // Branch operands are stale under a hazard, so the redirect waits.
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
          end else if (branch_taken) begin
            flush_id_c = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (stall_if_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Strobes are forced low for the whole reset interval, not just after the edge.
  assign stall_if    = reset_n & stall_if_c;
  assign stall_id    = reset_n & stall_id_c;
  assign stall_ex    = reset_n & stall_ex_c;
  assign stall_mem   = reset_n & stall_mem_c;
  assign flush_id    = reset_n & flush_id_c;
  assign flush_ex    = reset_n & flush_ex_c;
  assign flush_mem   = reset_n & flush_mem_c;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;
  import hazard_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n;
  forwarding_type_t ftype;
  logic             reg_we_ex, reg_we_mem, mem_rd_ex, mem_rd_mem;
  logic [4:0]       rd_ex, rd_mem, rs1_id, rs2_id;
  logic             mem_req_mem, mem_ack, branch_taken, trap;
  logic             stall_if, stall_id, stall_ex, stall_mem;
  logic             flush_id, flush_ex, flush_mem;
  logic [3:0]       stall_count;

  int n_total = 0;
  int n_pass  = 0;

  hazard_unit #(.N(5), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .forwarding_type_id(ftype),
    .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem), .mem_rd_ex(mem_rd_ex), .mem_rd_mem(mem_rd_mem),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .mem_req_mem(mem_req_mem), .mem_ack(mem_ack), .branch_taken(branch_taken), .trap(trap),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_wait, m_flush, m_pend, m_cnt;
  int n_wait, n_flush, n_pend, n_cnt;

  function automatic int model_hazard();
    int srcs[2];
    int hz;
    hz = 0;
    srcs[0] = int'(rs1_id);
    srcs[1] = int'(rs2_id);
    if (ftype == NoForward) return 0;
    for (int s = 0; s < 2; s++) begin
      if (srcs[s] != 0) begin
        if (mem_rd_ex && reg_we_ex && srcs[s] == int'(rd_ex)) hz = 1;
        if (ftype == ForwardDecode && mem_rd_mem && reg_we_mem && srcs[s] == int'(rd_mem)) hz = 1;
      end
    end
    return hz;
  endfunction

  initial begin
    int e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_fmem;
    m_wait = 0; m_flush = 0; m_pend = 0; m_cnt = 0;
    forever begin
      @(negedge clock);
      e_sif = 0; e_sid = 0; e_sex = 0; e_smem = 0; e_fid = 0; e_fex = 0; e_fmem = 0;
      if (!reset_n) begin
        m_wait = 0; m_flush = 0; m_pend = 0; m_cnt = 0;
        n_wait = 0; n_flush = 0; n_pend = 0; n_cnt = 0;
      end else begin
        n_wait = m_wait; n_flush = 0; n_pend = m_pend; n_cnt = m_cnt;
        if (m_wait && !mem_ack) begin
          e_sif = 1; e_sid = 1; e_sex = 1; e_smem = 1;
          n_pend = (m_pend || trap) ? 1 : 0;
        end else if (trap || (m_wait && m_pend)) begin
          e_fid = 1; e_fex = 1; e_fmem = 1;
          n_flush = 1; n_wait = 0; n_pend = 0;
        end else begin
          if (m_flush) e_fid = 1;
          else if (model_hazard() != 0) begin e_sif = 1; e_sid = 1; e_fex = 1; end
          else if (branch_taken && !m_wait) e_fid = 1;
          n_wait = (!m_wait && mem_req_mem && !mem_ack) ? 1 : 0;
        end
        if (e_sif != 0) n_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end
      chk("stall_if",    int'(stall_if),    e_sif);
      chk("stall_id",    int'(stall_id),    e_sid);
      chk("stall_ex",    int'(stall_ex),    e_sex);
      chk("stall_mem",   int'(stall_mem),   e_smem);
      chk("flush_id",    int'(flush_id),    e_fid);
      chk("flush_ex",    int'(flush_ex),    e_fex);
      chk("flush_mem",   int'(flush_mem),   e_fmem);
      chk("stall_count", int'(stall_count), m_cnt);
      @(posedge clock);
      if (!reset_n) begin
        m_wait = 0; m_flush = 0; m_pend = 0; m_cnt = 0;
      end else begin
        m_wait = n_wait; m_flush = n_flush; m_pend = n_pend; m_cnt = n_cnt;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ftype = NoForward;
    reg_we_ex = 0; reg_we_mem = 0; mem_rd_ex = 0; mem_rd_mem = 0;
    rd_ex = 0; rd_mem = 0; rs1_id = 0; rs2_id = 0;
    mem_req_mem = 0; mem_ack = 0; branch_taken = 0; trap = 0;
  endtask

  task automatic load_use_5();
    ftype = ForwardExecute; rs1_id = 5; rd_ex = 5; mem_rd_ex = 1; reg_we_ex = 1;
  endtask

  initial begin
    reset_n = 0;
    idle();
    step(); step();
    chk("rst_stall_if", int'(stall_if), 0);
    chk("rst_flush_id", int'(flush_id), 0);
    chk("rst_count", int'(stall_count), 0);
    reset_n = 1;
    step();

    // load-use against EX
    load_use_5();
    #1;
    chk("lu_stall_if", int'(stall_if), 1);
    chk("lu_stall_id", int'(stall_id), 1);
    chk("lu_flush_ex", int'(flush_ex), 1);
    chk("lu_flush_id", int'(flush_id), 0);
    step();
    mem_rd_ex = 0; reg_we_ex = 0; rd_ex = 0;
    #1;
    chk("lu_release", int'(stall_if), 0);
    chk("lu_count", int'(stall_count), 1);
    step();

    // x0 never hazards
    idle(); ftype = ForwardExecute; mem_rd_ex = 1; reg_we_ex = 1;
    #1;
    chk("x0_stall_if", int'(stall_if), 0);
    step();

    // decode consumer: load in EX then in MEM
    idle(); ftype = ForwardDecode; rs2_id = 7; rd_ex = 7; mem_rd_ex = 1; reg_we_ex = 1;
    #1;
    chk("dec_ex_stall", int'(stall_if), 1);
    step();
    rd_ex = 0; mem_rd_ex = 0; reg_we_ex = 0; rd_mem = 7; mem_rd_mem = 1; reg_we_mem = 1;
    #1;
    chk("dec_mem_stall", int'(stall_if), 1);
    step();
    idle();
    #1;
    chk("dec_done", int'(stall_if), 0);
    chk("dec_count", int'(stall_count), 3);
    step();

    // decode consumer with ALU producer in EX: forwarded, no stall
    ftype = ForwardDecode; rs1_id = 9; rd_ex = 9; reg_we_ex = 1;
    #1;
    chk("dec_alu_nostall", int'(stall_if), 0);
    step();
    idle();

    // memory wait: 3 wait cycles then ack
    mem_req_mem = 1;
    #1;
    chk("mw_req_cycle", int'(stall_mem), 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("mw_stall_if", int'(stall_if), 1);
      chk("mw_stall_ex", int'(stall_ex), 1);
      chk("mw_stall_mem", int'(stall_mem), 1);
      step();
    end
    mem_ack = 1;
    #1;
    chk("mw_ack_stall", int'(stall_mem), 0);
    chk("mw_count", int'(stall_count), 6);
    step();
    idle();
    step();

    // asynchronous reset during MEM_WAIT with count 7
    mem_req_mem = 1;
    step();
    chk("rw_stall", int'(stall_mem), 1);
    step();
    chk("rw_count7", int'(stall_count), 7);
    #2;
    reset_n = 0;
    #1;
    chk("rw_stall_if0", int'(stall_if), 0);
    chk("rw_stall_mem0", int'(stall_mem), 0);
    chk("rw_count0", int'(stall_count), 0);
    step();
    reset_n = 1;
    #1;
    chk("rw_idle", int'(stall_mem), 0);
    step();
    mem_ack = 1;
    step();
    idle();

    // request acked in its own cycle
    mem_req_mem = 1; mem_ack = 1;
    #1;
    chk("ack0_stall", int'(stall_mem), 0);
    step();
    idle();
    #1;
    chk("ack0_next", int'(stall_mem), 0);
    step();

    // trap in IDLE
    trap = 1;
    #1;
    chk("trap_fid", int'(flush_id), 1);
    chk("trap_fex", int'(flush_ex), 1);
    chk("trap_fmem", int'(flush_mem), 1);
    chk("trap_sif", int'(stall_if), 0);
    step();
    trap = 0;
    #1;
    chk("trap2_fid", int'(flush_id), 1);
    chk("trap2_fex", int'(flush_ex), 0);
    chk("trap2_fmem", int'(flush_mem), 0);
    step();
    chk("trap3_fid", int'(flush_id), 0);
    step();

    // trap during MEM_WAIT is deferred to the ack cycle
    mem_req_mem = 1;
    step();
    trap = 1;
    #1;
    chk("dt_fmem", int'(flush_mem), 0);
    chk("dt_smem", int'(stall_mem), 1);
    step();
    trap = 0;
    #1;
    chk("dt_hold_fid", int'(flush_id), 0);
    step();
    mem_ack = 1;
    #1;
    chk("dt_ack_fid", int'(flush_id), 1);
    chk("dt_ack_fex", int'(flush_ex), 1);
    chk("dt_ack_fmem", int'(flush_mem), 1);
    chk("dt_ack_sif", int'(stall_if), 0);
    step();
    idle();
    #1;
    chk("dt_flush_fid", int'(flush_id), 1);
    chk("dt_flush_fmem", int'(flush_mem), 0);
    step();
    chk("dt_done", int'(flush_id), 0);
    step();

    // branch redirect, alone and under a load-use hazard
    branch_taken = 1;
    #1;
    chk("br_fid", int'(flush_id), 1);
    step();
    branch_taken = 0;
    #1;
    chk("br_done", int'(flush_id), 0);
    step();
    load_use_5(); branch_taken = 1;
    #1;
    chk("brhz_sif", int'(stall_if), 1);
    chk("brhz_fid", int'(flush_id), 0);
    step();
    idle();
    #1;
    chk("brhz_count", int'(stall_count), 3);
    step();

    // counter saturation at 4'hF
    load_use_5();
    repeat (20) step();
    chk("sat_count", int'(stall_count), 15);
    step();
    chk("sat_hold", int'(stall_count), 15);
    idle();
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
